// File: rtl/branch_resolve_rv32i_if.sv
// Request/result bundle for the RV32I branch resolver.
// master = upstream producer + fetch-side consumer, slave = resolver.
interface branch_resolve_rv32i_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_next_pc;
    logic            out_misalign;
    logic            out_illegal;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, flush, out_ready,
        input  in_ready, out_valid, out_taken, out_next_pc, out_misalign, out_illegal
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, flush, out_ready,
        output in_ready, out_valid, out_taken, out_next_pc, out_misalign, out_illegal
    );
endinterface

// File: rtl/branch_resolve_rv32i.sv
// RV32I conditional-branch resolver with a one-entry registered result slot.
// Optional taken/not-taken counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve_rv32i #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    branch_resolve_rv32i_if.slave   br
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]             stat_taken,
    output logic [31:0]             stat_not_taken
`endif
);
    localparam int unsigned STAT_W = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic            taken_q, taken_d;
    logic [XLEN-1:0] next_pc_q, next_pc_d;
    logic            misalign_q, misalign_d;
    logic            illegal_q, illegal_d;

    logic            in_ready_c;
    logic            accept_c;
    logic            eq_c, lt_c, ltu_c;
    logic [XLEN-1:0] target_c, seq_pc_c;

    assign in_ready_c = (state_q == EMPTY) || br.out_ready;
    assign accept_c   = br.in_valid && in_ready_c && !br.flush;

    assign eq_c     = (br.in_rs1 == br.in_rs2);
    assign lt_c     = ($signed(br.in_rs1) < $signed(br.in_rs2));
    assign ltu_c    = (br.in_rs1 < br.in_rs2);
    assign target_c = br.in_pc + br.in_imm;
    assign seq_pc_c = br.in_pc + XLEN'(4);

    // Branch decision and the payload that gets loaded on an accept
    always_comb begin
        taken_d    = 1'b0;
        illegal_d  = 1'b0;
        unique case (br.in_funct3)
            F3_BEQ:  taken_d = eq_c;
            F3_BNE:  taken_d = !eq_c;
            F3_BLT:  taken_d = lt_c;
            F3_BGE:  taken_d = !lt_c;
            F3_BLTU: taken_d = ltu_c;
            F3_BGEU: taken_d = !ltu_c;
            default: illegal_d = 1'b1;
        endcase
        next_pc_d  = taken_d ? target_c : seq_pc_c;
        misalign_d = taken_d && (target_c[1:0] != 2'b00);
    end

    // Slot occupancy; flush wins over both accept and drain
    always_comb begin
        state_d = state_q;
        if (br.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept_c) state_d = FULL;
                FULL:  if (br.out_ready) state_d = accept_c ? FULL : EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_q    <= 1'b0;
            next_pc_q  <= RESET_PC;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (accept_c) begin
            taken_q    <= taken_d;
            next_pc_q  <= next_pc_d;
            misalign_q <= misalign_d;
            illegal_q  <= illegal_d;
        end
    end

    assign br.in_ready     = in_ready_c;
    assign br.out_valid    = (state_q == FULL);
    assign br.out_taken    = taken_q;
    assign br.out_next_pc  = next_pc_q;
    assign br.out_misalign = misalign_q;
    assign br.out_illegal  = illegal_q;

`ifdef BRANCH_STATS_EN
    logic              handshake_c;
    logic [STAT_W-1:0] stat_taken_q, stat_not_taken_q;

    assign handshake_c = (state_q == FULL) && br.out_ready && !br.flush;

    // Illegal results carry taken_q=0, so they land in the not-taken count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_taken_q     <= '0;
            stat_not_taken_q <= '0;
        end else if (handshake_c) begin
            if (taken_q) stat_taken_q     <= stat_taken_q + STAT_W'(1);
            else         stat_not_taken_q <= stat_not_taken_q + STAT_W'(1);
        end
    end

    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
`endif
endmodule

// File: tb/tb_branch_resolve_rv32i.sv
// Directed self-checking bench for branch_resolve_rv32i.
module tb_branch_resolve_rv32i;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_rv32i_if #(.XLEN(32)) bus ();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_not_taken;
`endif

    branch_resolve_rv32i #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .br             (bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic v, input logic t,
                             input logic [31:0] pc, input logic m, input logic il);
        check({tag, ".valid"},    32'(bus.out_valid),    32'(v));
        check({tag, ".taken"},    32'(bus.out_taken),    32'(t));
        check({tag, ".next_pc"},  bus.out_next_pc,       pc);
        check({tag, ".misalign"}, 32'(bus.out_misalign), 32'(m));
        check({tag, ".illegal"},  32'(bus.out_illegal),  32'(il));
    endtask

    task automatic drive(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_funct3 = f3;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_pc     = pc;
        bus.in_imm    = imm;
    endtask

    // One request, accepted on the next edge; returns #1 after that edge
    task automatic send(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm);
        drive(f3, rs1, rs2, pc, imm);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_funct3 = 3'b000;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_pc     = '0;
        bus.in_imm    = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        #2;
        check_res("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("reset.in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        send(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20);
        check_res("blt_neg", 1'b1, 1'b1, 32'h120, 1'b0, 1'b0);
        send(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20);
        check_res("bltu", 1'b1, 1'b0, 32'h104, 1'b0, 1'b0);
        send(3'b111, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20);
        check_res("bgeu", 1'b1, 1'b1, 32'h120, 1'b0, 1'b0);
        send(3'b000, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8);
        check_res("beq_wrap", 1'b1, 1'b1, 32'h4, 1'b0, 1'b0);
        send(3'b000, 32'd5, 32'd5, 32'h100, 32'd6);
        check_res("beq_misalign", 1'b1, 1'b1, 32'h106, 1'b1, 1'b0);
        send(3'b010, 32'd5, 32'd5, 32'h200, 32'h40);
        check_res("illegal010", 1'b1, 1'b0, 32'h204, 1'b0, 1'b1);
        send(3'b011, 32'd1, 32'd2, 32'h210, 32'h40);
        check_res("illegal011", 1'b1, 1'b0, 32'h214, 1'b0, 1'b1);
        send(3'b101, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h300, 32'h10);
        check_res("bge_equal", 1'b1, 1'b1, 32'h310, 1'b0, 1'b0);
        send(3'b101, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10);
        check_res("bge_neg", 1'b1, 1'b0, 32'h304, 1'b0, 1'b0);
        send(3'b001, 32'd5, 32'd5, 32'h300, 32'h10);
        check_res("bne_equal", 1'b1, 1'b0, 32'h304, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("drain.valid", 32'(bus.out_valid), 32'd0);

        // Backpressure: result held while the next request waits
        bus.out_ready = 1'b0;
        send(3'b001, 32'd1, 32'd2, 32'h400, 32'h40);
        check_res("bp_load", 1'b1, 1'b1, 32'h440, 1'b0, 1'b0);
        drive(3'b000, 32'd1, 32'd2, 32'h500, 32'h10);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp.in_ready", 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            check_res("bp_hold", 1'b1, 1'b1, 32'h440, 1'b0, 1'b0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_res("bp_next", 1'b1, 1'b0, 32'h504, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("bp_drain.valid", 32'(bus.out_valid), 32'd0);

        // Four back-to-back results
        for (int i = 0; i < 4; i++) begin
            drive(3'b000, 32'd0, 32'd0, 32'h1000 + 32'(16 * i), 32'h100);
            @(posedge clk); #1;
            check_res("stream", 1'b1, 1'b1, 32'h1100 + 32'(16 * i), 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_drain.valid", 32'(bus.out_valid), 32'd0);

        // Flush while full with a request pending
        bus.out_ready = 1'b0;
        send(3'b000, 32'd0, 32'd0, 32'h600, 32'h8);
        check_res("flush_pre", 1'b1, 1'b1, 32'h608, 1'b0, 1'b0);
        drive(3'b000, 32'd0, 32'd0, 32'h700, 32'h8);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        check("flush.valid", 32'(bus.out_valid), 32'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("flush_drop.valid", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset while full
        send(3'b100, 32'd1, 32'd2, 32'h800, 32'h20);
        check_res("rst_pre", 1'b1, 1'b1, 32'h820, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_res("rst_async", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_post.valid", 32'(bus.out_valid), 32'd0);

`ifdef BRANCH_STATS_EN
        check("stat_reset.taken", stat_taken, 32'd0);
        check("stat_reset.not_taken", stat_not_taken, 32'd0);
        send(3'b000, 32'd7, 32'd7, 32'h900, 32'h10);
        send(3'b001, 32'd7, 32'd7, 32'h900, 32'h10);
        send(3'b110, 32'd1, 32'd2, 32'h900, 32'h10);
        send(3'b010, 32'd1, 32'd2, 32'h900, 32'h10);
        send(3'b111, 32'd3, 32'd2, 32'h900, 32'h10);
        @(posedge clk); #1;
        check("stat.taken", stat_taken, 32'd3);
        check("stat.not_taken", stat_not_taken, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
